cla_serial_adder_ctrl: RTL
==========================

Name: cla_serial_adder_ctrl

Overview:
- Sequencer that performs WIDTH-bit additions by time-multiplexing one 4-bit carry-look-ahead adder cell, one nibble per cycle, LSB nibble first.
- Carry is registered between nibbles.
- Sits between a valid/ready operand producer and a valid/ready result consumer.
- Used where a full-width adder is too costly and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration-time assertion).
- NIB, WIDTH/4, derived nibble count; local parameter, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for nibble 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of the top nibble
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock domain (clk). Reset (rst) is synchronous and active-high.
- Reset has priority over all other inputs, including mid-RUN and mid-DONE. On reset:
  - state returns to IDLE; any operation in progress is discarded.
  - in_valid is ignored in that cycle.
  - Output reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Internal operand shift registers, nibble counter and carry register are cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b and cin into the carry register; clear the counter; go to RUN.
- RUN:
  - in_ready=0.
  - The 4-bit CLA cell adds the low nibbles of the A/B shift registers plus the carry register.
  - At each edge:
    - the sum nibble is shifted into the MSB end of the sum register;
    - the A/B registers shift right by 4;
    - the carry register takes the cell's carry-out;
    - the counter increments.
  - When the counter equals NIB-1 at the edge, go to DONE.
- DONE:
  - out_valid=1; sum and cout hold stable until the handshake completes.
  - cout equals the final carry register value.
  - On out_ready, go to IDLE at that edge; out_valid drops in the next cycle.
- Latency: out_valid rises exactly NIB cycles after the accept edge. The minimum initiation interval is NIB+2 cycles.
- No overlap: in_ready=0 throughout RUN and DONE. Operands presented then are not consumed.
- out_ready asserted outside DONE has no effect.
- sum/cout keep the last result in IDLE until the next operation's RUN overwrites them. Consumers must sample only when out_valid=1.
- Arithmetic:
  - {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
  - Carry ripples only through the registered carry between nibbles; there is no combinational path between nibbles.
- Boundary cases:
  - WIDTH=4 gives a single RUN cycle.
  - All-ones plus cin=1 must propagate carry through every nibble.

Optional Feature:
- Macro: CLA_SERIAL_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), captured at accept.
  - When op_sub=1, B is inverted at capture and the initial carry is forced to 1, ignoring cin. Result is a - b.
  - cout=1 means no borrow.
- Undefined:
  - The op_sub port is absent.
  - Behaviour is pure addition as above.

Decomposition:
- Shared package cla_serial_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - NIBBLE_W=4 constant;
  - the counter-width function ($clog2(NIB), minimum 1).
- One sub-module instance: the team's existing 4-bit CLA cell carry_look_ahead_adder_4bit as the datapath.
  - Its nibble carry-out is generated locally from the same G/P terms if the cell does not expose it.
- FSM, counter and shift registers stay in this module.

Test Plan (WIDTH=16 unless noted):
- a=0x1234, b=0x4321, cin=0 → out_valid exactly 4 cycles after accept; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE → sum/cout/out_valid stable; in_ready=0 and a second in_valid not consumed; accepted only after out_ready and the return to IDLE.
- Reset mid-RUN after 2 nibbles (a=0xAAAA, b=0x5555) → next cycle IDLE, in_ready=1, out_valid=0, sum=0, cout=0; a new op a=0x0001, b=0x0001 yields 0x0002.
- WIDTH=4: a=0x9, b=0x8, cin=1 → out_valid 1 cycle after accept; sum=0x2, cout=1.
- With CLA_SERIAL_SUB_EN: a=0x0005, b=0x0007, op_sub=1 → sum=0xFFFE, cout=0. Also a=0x0007, b=0x0005 → sum=0x0002, cout=1.

Source files
------------

// File: rtl/cla_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial CLA adder sequencer.
package cla_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that must reach nib-1; never narrower than one bit.
    function automatic int cnt_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/cla_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for cla_serial_adder_ctrl.
// Optional macro CLA_SERIAL_SUB_EN adds the op_sub operand-control signal.
interface cla_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_SERIAL_SUB_EN
    logic             op_sub;
`endif

    modport master (
`ifdef CLA_SERIAL_SUB_EN
        output op_sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
`ifdef CLA_SERIAL_SUB_EN
        input  op_sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/cla_serial_adder_ctrl_cla4.sv
// 4-bit carry-look-ahead adder cell: all carries formed directly from G/P terms.
module carry_look_ahead_adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign sum_o = p ^ c;

endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit CLA cell, one nibble per cycle, LSB first.
// Optional macro CLA_SERIAL_SUB_EN enables a - b via op_sub.
module cla_serial_adder_ctrl
    import cla_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_serial_adder_ctrl_if.slave  bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(NIB);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("cla_serial_adder_ctrl: WIDTH must be a positive multiple of 4");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic [NIBBLE_W-1:0]       nib_sum;
    logic                      nib_cout;
    logic [WIDTH+NIBBLE_W-1:0] sum_shift;

    carry_look_ahead_adder_4bit u_cla (
        .a_i   (a_q[NIBBLE_W-1:0]),
        .b_i   (b_q[NIBBLE_W-1:0]),
        .c_i   (carry_q),
        .sum_o (nib_sum),
        .c_o   (nib_cout)
    );

    // New nibble enters at the top so the LSB nibble lands at bit 0 after NIB shifts.
    assign sum_shift = {nib_sum, sum_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    a_d   = bus.a;
`ifdef CLA_SERIAL_SUB_EN
                    // Two's-complement subtract: invert B and force the initial carry.
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub | bus.cin;
`else
                    b_d     = bus.b;
                    carry_d = bus.cin;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_shift[WIDTH+NIBBLE_W-1:NIBBLE_W];
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                carry_d = nib_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIB - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = carry_q;

endmodule
